pipe_ctrl: RTL



---
 rtl/pipe_ctrl_if.sv | 54 +++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: pipeline status into pipe_ctrl and stall/flush/forwarding commands back.
// "master" is the pipeline datapath side and "slave" is the controller side.
interface pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] i_id_rs1;
  logic [REG_ADDR_W-1:0] i_id_rs2;
  logic                  i_id_rs1_used;
  logic                  i_id_rs2_used;
  logic [REG_ADDR_W-1:0] i_ex_rs1;
  logic [REG_ADDR_W-1:0] i_ex_rs2;
  logic [REG_ADDR_W-1:0] i_ex_rd;
  logic                  i_ex_reg_write;
  logic                  i_ex_is_load;
  logic                  i_ex_redirect;
  logic [REG_ADDR_W-1:0] i_mem_rd;
  logic                  i_mem_reg_write;
  logic                  i_mem_req;
  logic                  i_mem_ready;
  logic [REG_ADDR_W-1:0] i_wb_rd;
  logic                  i_wb_reg_write;
  logic                  o_stall_if;
  logic                  o_stall_id;
  logic                  o_stall_ex;
  logic                  o_stall_mem;
  logic                  o_flush_ex;
  logic                  o_flush_id;
  logic                  o_flush_wb;
  logic [1:0]            o_fwd_a;
  logic [1:0]            o_fwd_b;
  logic [1:0]            o_state;
  logic [31:0]           o_stall_count;
  logic                  o_mem_timeout;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_write, i_ex_is_load, i_ex_redirect,
    output i_mem_rd, i_mem_reg_write, i_mem_req, i_mem_ready,
    output i_wb_rd, i_wb_reg_write,
    input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
    input  o_flush_ex, o_flush_id, o_flush_wb,
    input  o_fwd_a, o_fwd_b, o_state, o_stall_count, o_mem_timeout
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_reg_write, i_ex_is_load, i_ex_redirect,
    input  i_mem_rd, i_mem_reg_write, i_mem_req, i_mem_ready,
    input  i_wb_rd, i_wb_reg_write,
    output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
    output o_flush_ex, o_flush_id, o_flush_wb,
    output o_fwd_a, o_fwd_b, o_state, o_stall_count, o_mem_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for the five-stage RV32I pipeline: stall and flush sequencing,
// EX forwarding select, saturating stall-cycle counter and sticky memory-timeout flag.
module pipe_ctrl #(
  parameter int          REG_ADDR_W       = 5,
  parameter int          MEM_TIMEOUT      = 255,
  parameter logic [31:0] STALL_COUNT_INIT = 32'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] wait_cnt_reg;
  logic [31:0] stall_count_reg;
  logic        timeout_reg;

  logic mem_wait, lu_hazard, rs1_hit, rs2_hit;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_wb;

  assign mem_wait  = bus.i_mem_req & ~bus.i_mem_ready;
  assign rs1_hit   = bus.i_id_rs1_used & (bus.i_id_rs1 == bus.i_ex_rd);
  assign rs2_hit   = bus.i_id_rs2_used & (bus.i_id_rs2 == bus.i_ex_rd);
  assign lu_hazard = bus.i_ex_is_load & bus.i_ex_reg_write & (bus.i_ex_rd != '0) & (rs1_hit | rs2_hit);

  // Cause priority: timeout > memory wait > redirect > load-use.
  always_comb begin
    state_next = state_reg;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    flush_wb   = 1'b0;
    if (state_reg == ST_TIMEOUT) begin
      {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
      flush_wb = 1'b1;
    end else if (mem_wait) begin
      {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
      flush_wb   = 1'b1;
      state_next = (wait_cnt_reg == WAIT_LAST) ? ST_TIMEOUT : ST_MEM_WAIT;
    end else if (bus.i_ex_redirect) begin
      // The younger instruction is squashed, so any load-use hazard on it is moot.
      flush_id   = 1'b1;
      flush_ex   = 1'b1;
      state_next = ST_RUN;
    end else if (lu_hazard) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      flush_ex   = 1'b1;
      state_next = ST_LU_STALL;
    end else begin
      state_next = ST_RUN;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [REG_ADDR_W-1:0] rs;
    logic [1:0]            sel;
    assign rs = (gi == 0) ? bus.i_ex_rs1 : bus.i_ex_rs2;
    always_comb begin
      sel = 2'b00;
      if (bus.i_mem_reg_write && (bus.i_mem_rd != '0) && (bus.i_mem_rd == rs)) begin
        sel = 2'b01;
      end else if (bus.i_wb_reg_write && (bus.i_wb_rd != '0) && (bus.i_wb_rd == rs)) begin
        sel = 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= ST_RUN;
      wait_cnt_reg    <= 16'd0;
      stall_count_reg <= STALL_COUNT_INIT;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= mem_wait ? wait_cnt_reg + 16'd1 : 16'd0;
      if (stall_if && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (state_next == ST_TIMEOUT) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  // Commands are held inactive while reset is asserted.
  assign bus.o_stall_if    = i_rst_n & stall_if;
  assign bus.o_stall_id    = i_rst_n & stall_id;
  assign bus.o_stall_ex    = i_rst_n & stall_ex;
  assign bus.o_stall_mem   = i_rst_n & stall_mem;
  assign bus.o_flush_id    = i_rst_n & flush_id;
  assign bus.o_flush_ex    = i_rst_n & flush_ex;
  assign bus.o_flush_wb    = i_rst_n & flush_wb;
  assign bus.o_fwd_a       = i_rst_n ? g_fwd[0].sel : 2'b00;
  assign bus.o_fwd_b       = i_rst_n ? g_fwd[1].sel : 2'b00;
  assign bus.o_state       = state_reg;
  assign bus.o_stall_count = stall_count_reg;
  assign bus.o_mem_timeout = timeout_reg;
endmodule
